// File: rtl/bus_arbiter_pkg.sv
// Shared types for the IF/MEM bus arbiter: FSM state encoding, the registered
// bus command, and the default abort timeout.
package bus_arbiter_pkg;

  localparam int unsigned WAIT_MAX_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_BUSY = 3'd1,
    ST_D_DONE = 3'd2,
    ST_I_BUSY = 3'd3,
    ST_I_DONE = 3'd4,
    ST_I_DROP = 3'd5
  } state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic bus_cmd_t fetch_cmd(input logic [31:0] addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.sel   = 4'b1111;
    c.addr  = addr;
    c.wdata = 32'h0;
    return c;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates one request/ack bus between instruction fetch and the MEM data port,
// stalling the pipeline until each access completes or times out.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | no access in flight; data request wins over fetch
//  D_BUSY   | data access issued, waiting for ack or timeout
//  D_DONE   | data access finished; MEM released for this cycle
//  I_BUSY   | fetch issued, waiting for ack or timeout
//  I_DONE   | fetch finished; IF released for this cycle
//  I_DROP   | fetch flushed mid-flight; waiting out the bus, data discarded
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  state_e           state_q, state_d;
  bus_cmd_t         cmd_q, cmd_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;

  assign timeout = (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      if_data_q  <= 32'h0;
      mem_data_q <= 32'h0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      req_q      <= req_d;
      err_q      <= err_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The counter defaults to zero, which also clears it on every BUSY/DROP entry.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    req_d      = req_q;
    err_d      = 1'b0;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    wait_cnt_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          cmd_d   = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, wdata: mem_data_i};
          req_d   = 1'b1;
          state_d = ST_D_BUSY;
        end else if (if_ce_i && !flush_i) begin
          cmd_d   = fetch_cmd(if_addr_i);
          req_d   = 1'b1;
          state_d = ST_I_BUSY;
        end
      end

      ST_D_BUSY: begin
        if (bus_ack_i || timeout) begin
          req_d   = 1'b0;
          err_d   = !bus_ack_i;
          state_d = ST_D_DONE;
          if (!cmd_q.we) begin
            mem_data_d = bus_ack_i ? bus_rdata_i : 32'h0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      // A flush coinciding with completion skips I_DROP: nothing is left to wait for.
      ST_I_BUSY: begin
        if (bus_ack_i || timeout) begin
          req_d = 1'b0;
          err_d = !bus_ack_i;
          if (flush_i) begin
            state_d = ST_IDLE;
          end else begin
            if_data_d = bus_ack_i ? bus_rdata_i : 32'h0;
            state_d   = ST_I_DONE;
          end
        end else if (flush_i) begin
          state_d = ST_I_DROP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_I_DROP: begin
        if (bus_ack_i || timeout) begin
          req_d   = 1'b0;
          err_d   = !bus_ack_i;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_D_DONE, ST_I_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_stallreq_o = mem_ce_i && (state_q != ST_D_DONE);
    if_stallreq_o  = if_ce_i && (state_q != ST_I_DONE) && !flush_i;
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = cmd_q.we;
  assign bus_sel_o   = cmd_q.sel;
  assign bus_addr_o  = cmd_q.addr;
  assign bus_wdata_o = cmd_q.wdata;
  assign bus_err_o   = err_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed and randomized episodes checked
// against a transaction-timeline model computed from the access rules.
module tb_bus_arbiter;

  localparam int unsigned WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stallreq_o;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_mem = 32'h0;
  logic [31:0] exp_if  = 32'h0;

  typedef struct {
    bit          has_m;
    bit          m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    int          d_m;
    bit          has_i;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    int          d_i;
    bit          do_flush;
    int          f;
    bit          noise;
    int          noise_t;
    int          gap;
  } ep_t;

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_stallreq_o(if_stallreq_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_stallreq_o(mem_stallreq_o), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    if_ce_i     = 1'b0;
    if_addr_i   = 32'h0;
    mem_ce_i    = 1'b0;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'h0;
    mem_addr_i  = 32'h0;
    mem_data_i  = 32'h0;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
  endtask

  function automatic ep_t ep_zero();
    ep_t e;
    e.has_m = 0; e.m_we = 0; e.m_sel = 4'hF; e.m_addr = 32'h0; e.m_wdata = 32'h0;
    e.m_rdata = 32'h0; e.d_m = 0; e.has_i = 0; e.i_addr = 32'h0; e.i_rdata = 32'h0;
    e.d_i = 0; e.do_flush = 0; e.f = 0; e.noise = 0; e.noise_t = 0; e.gap = 1;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".req"},   bus_req_o,   0);
    check_eq({tag, ".we"},    bus_we_o,    0);
    check_eq({tag, ".sel"},   bus_sel_o,   0);
    check_eq({tag, ".addr"},  bus_addr_o,  0);
    check_eq({tag, ".wdata"}, bus_wdata_o, 0);
    check_eq({tag, ".err"},   bus_err_o,   0);
    check_eq({tag, ".idata"}, if_data_o,   0);
    check_eq({tag, ".mdata"}, mem_data_o,  0);
  endtask

  // Episode starts with the arbiter idle. The slave acks the n-th bus cycle of a
  // transaction (n = delay) unless delay >= WAIT_MAX, in which case it never acks.
  task automatic run_episode(input ep_t e);
    int eff_m, m_done, i_start, i_lastk, i_end, flush_t, last, total;
    bit ack_m_ok, ack_i_ok;
    int k, cur, txn_idx, dly;
    bit prev_req;
    logic [31:0] rd;
    bit mce, ice, fl, exp_req, exp_err, exp_ms, exp_is;

    ack_m_ok = e.d_m < int'(WAIT_MAX);
    eff_m    = ack_m_ok ? e.d_m : int'(WAIT_MAX) - 1;
    m_done   = e.has_m ? eff_m + 2 : -1;
    i_start  = e.has_m ? m_done + 1 : 0;
    ack_i_ok = e.d_i < int'(WAIT_MAX);
    if (!e.do_flush)             i_lastk = ack_i_ok ? e.d_i : int'(WAIT_MAX) - 1;
    else if (ack_i_ok)           i_lastk = e.d_i;
    else if (e.f == WAIT_MAX-1)  i_lastk = e.f;
    else                         i_lastk = e.f + int'(WAIT_MAX);
    i_end   = i_start + 2 + i_lastk;
    flush_t = i_start + 1 + e.f;
    last    = e.has_i ? i_end : m_done;
    total   = last + 1 + e.gap;

    k = 0; cur = 0; txn_idx = 0; prev_req = 0;
    for (int t = 0; t < total; t++) begin
      @(posedge clk); #1;
      mce = e.has_m && (t <= m_done);
      ice = e.has_i && (e.do_flush ? (t < flush_t) : (t <= i_end));
      fl  = (e.do_flush && t == flush_t) || (e.noise && !e.has_i && t == e.noise_t);
      mem_ce_i   = mce;
      mem_we_i   = e.m_we;
      mem_sel_i  = e.m_sel;
      mem_addr_i = e.m_addr;
      mem_data_i = e.m_wdata;
      if_ce_i    = ice;
      if_addr_i  = e.i_addr;
      flush_i    = fl;

      if (bus_req_o) begin
        if (!prev_req) begin k = 0; cur = txn_idx; txn_idx++; end
        else k++;
      end
      prev_req = bus_req_o;
      dly = (cur == 0 && e.has_m) ? e.d_m : e.d_i;
      rd  = (cur == 0 && e.has_m) ? e.m_rdata : e.i_rdata;
      bus_ack_i   = bus_req_o && (k == dly) && (dly < int'(WAIT_MAX));
      bus_rdata_i = bus_ack_i ? rd : $urandom();

      exp_req = (e.has_m && t >= 1 && t <= 1 + eff_m) ||
                (e.has_i && t >= i_start + 1 && t <= i_start + 1 + i_lastk);
      exp_err = (e.has_m && !ack_m_ok && t == m_done) ||
                (e.has_i && !ack_i_ok && t == i_end);
      if (e.has_m && !e.m_we && t == m_done) exp_mem = ack_m_ok ? e.m_rdata : 32'h0;
      if (e.has_i && !e.do_flush && t == i_end) exp_if = ack_i_ok ? e.i_rdata : 32'h0;
      exp_ms = mce && (t != m_done);
      exp_is = ice && !fl && !(!e.do_flush && t == i_end);

      @(negedge clk);
      check_eq("bus_req", bus_req_o, exp_req);
      check_eq("bus_err", bus_err_o, exp_err);
      check_eq("mem_stall", mem_stallreq_o, exp_ms);
      check_eq("if_stall", if_stallreq_o, exp_is);
      check_eq("mem_data", mem_data_o, exp_mem);
      check_eq("if_data", if_data_o, exp_if);
      if (exp_req && bus_req_o) begin
        if (e.has_m && t <= 1 + eff_m) begin
          check_eq("d.we", bus_we_o, e.m_we);
          check_eq("d.sel", bus_sel_o, e.m_sel);
          check_eq("d.addr", bus_addr_o, e.m_addr);
          check_eq("d.wdata", bus_wdata_o, e.m_wdata);
        end else begin
          check_eq("i.we", bus_we_o, 0);
          check_eq("i.sel", bus_sel_o, 4'hF);
          check_eq("i.addr", bus_addr_o, e.i_addr);
        end
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ep_t e;
    int eff;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check_eq("reset.mstall", mem_stallreq_o, 0);
    check_eq("reset.istall", if_stallreq_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // fetch only, ack on the third bus cycle
    e = ep_zero(); e.has_i = 1; e.i_addr = 32'h100; e.i_rdata = 32'h2401_0001; e.d_i = 2;
    run_episode(e);
    // simultaneous load and fetch
    e = ep_zero(); e.has_m = 1; e.m_addr = 32'h200; e.m_rdata = 32'h1122_3344; e.d_m = 1;
    e.has_i = 1; e.i_addr = 32'h104; e.i_rdata = 32'h2402_0002; e.d_i = 0;
    run_episode(e);
    // byte store
    e = ep_zero(); e.has_m = 1; e.m_we = 1; e.m_sel = 4'b0010; e.m_addr = 32'h201;
    e.m_wdata = 32'h5A5A_5A5A; e.m_rdata = 32'hFFFF_0000; e.d_m = 2;
    run_episode(e);
    // flush while fetch in flight
    e = ep_zero(); e.has_i = 1; e.i_addr = 32'h108; e.i_rdata = 32'hDEAD_BEEF; e.d_i = 3;
    e.do_flush = 1; e.f = 1;
    run_episode(e);
    // load timeout
    e = ep_zero(); e.has_m = 1; e.m_addr = 32'h204; e.m_rdata = 32'h7777_7777; e.d_m = WAIT_MAX;
    run_episode(e);
    // ack on the timeout cycle, then fetch timeout
    e = ep_zero(); e.has_m = 1; e.m_addr = 32'h208; e.m_rdata = 32'hA5A5_0F0F; e.d_m = WAIT_MAX - 1;
    e.has_i = 1; e.i_addr = 32'h10C; e.i_rdata = 32'h3333_3333; e.d_i = WAIT_MAX;
    run_episode(e);
    // flushed fetch that never acks times out in the drop state
    e = ep_zero(); e.has_i = 1; e.i_addr = 32'h110; e.i_rdata = 32'h4444_4444; e.d_i = WAIT_MAX;
    e.do_flush = 1; e.f = 0;
    run_episode(e);
    // flush with no fetch in flight
    e = ep_zero(); e.has_m = 1; e.m_addr = 32'h20C; e.m_rdata = 32'h5555_1234; e.d_m = 1;
    e.noise = 1; e.noise_t = 1;
    run_episode(e);

    for (int n = 0; n < 200; n++) begin
      e = ep_zero();
      e.has_m   = 1'($urandom_range(0, 1));
      e.has_i   = 1'($urandom_range(0, 1));
      if (!e.has_m && !e.has_i) e.has_i = 1;
      e.m_we    = 1'($urandom_range(0, 1));
      e.m_sel   = 4'($urandom_range(1, 15));
      e.m_addr  = $urandom() & 32'hFFFF_FFFC;
      e.m_wdata = $urandom();
      e.m_rdata = $urandom();
      e.d_m     = int'($urandom_range(0, WAIT_MAX));
      e.i_addr  = $urandom() & 32'hFFFF_FFFC;
      e.i_rdata = $urandom();
      e.d_i     = int'($urandom_range(0, WAIT_MAX));
      e.do_flush = e.has_i && ($urandom_range(0, 3) == 0);
      eff       = (e.d_i < int'(WAIT_MAX)) ? e.d_i : int'(WAIT_MAX) - 1;
      e.f       = int'($urandom_range(0, eff));
      e.noise   = !e.has_i && ($urandom_range(0, 2) == 0);
      e.noise_t = int'($urandom_range(0, WAIT_MAX + 1));
      e.gap     = int'($urandom_range(0, 2));
      run_episode(e);
    end

    // leave nonzero data behind so reset clearing is visible
    e = ep_zero(); e.has_m = 1; e.m_addr = 32'h300; e.m_rdata = 32'h1357_2468; e.d_m = 0;
    e.has_i = 1; e.i_addr = 32'h114; e.i_rdata = 32'h0BAD_F00D; e.d_i = 1;
    run_episode(e);

    // reset during D_BUSY, then a late ack
    @(posedge clk); #1;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h304;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ce_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid.busy", bus_req_o, 1);
    @(posedge clk); #1;
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    exp_mem = 32'h0; exp_if = 32'h0;
    @(negedge clk);
    check_all_zero("rstmid");
    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    @(negedge clk);
    check_eq("late_ack.req", bus_req_o, 0);
    check_eq("late_ack.err", bus_err_o, 0);
    check_eq("late_ack.mdata", mem_data_o, 0);
    check_eq("late_ack.mstall", mem_stallreq_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
